delay_timer_monitor: RTL

Measurement block on the receiving side of the delay timer's output. It watches the timer's trigger input and delayed output, then reports two values. The first is the lead time from the selected trigger edge to the first output edge. The second is the width of the pulse that follows. Test logic uses these values to characterise each timer mode in-system, one armed measurement at a time.

---
 rtl/delay_timer_monitor_if.sv | 25 ++
 rtl/delay_timer_monitor.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/delay_timer_monitor_if.sv
// rtl/delay_timer_monitor_if.sv - Control and result signals between test logic and the delay timer monitor.
interface delay_timer_monitor_if #(
  parameter int unsigned CNT_W = 8
) ();
  logic             arm;
  logic             trig_edge_sel;
  logic             trigger;
  logic             delay_in;
  logic             busy;
  logic             meas_valid;
  logic [CNT_W-1:0] lead_cnt;
  logic [CNT_W-1:0] width_cnt;
  logic             edge_pol;
  logic             timeout;

  modport master (
    output arm, trig_edge_sel, trigger, delay_in,
    input  busy, meas_valid, lead_cnt, width_cnt, edge_pol, timeout
  );

  modport slave (
    input  arm, trig_edge_sel, trigger, delay_in,
    output busy, meas_valid, lead_cnt, width_cnt, edge_pol, timeout
  );
endinterface

// File: rtl/delay_timer_monitor.sv
// rtl/delay_timer_monitor.sv - Measures trigger-to-output lead time and following pulse width of the delay timer.
module delay_timer_monitor #(
  parameter int unsigned      CNT_W   = 8,
  parameter logic [CNT_W-1:0] TIMEOUT = 8'hFF
) (
  input logic                  clk,
  input logic                  reset,
  delay_timer_monitor_if.slave mon
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_LEAD,
    S_WIDTH,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic             trig_s1, trig_s2, dly_s1, dly_s2;
  logic             sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] lead_q, lead_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic             pol_q, pol_d;
  logic             tmo_q, tmo_d;
  logic             busy_q, valid_q;

  logic             trig_rise, trig_fall, dly_rise, dly_fall;
  logic             trig_hit, dly_hit, close_hit;
  logic [CNT_W-1:0] elapsed;

  // Two-flop synchronisers; both inputs share the same latency so edge spacing is preserved.
  always_ff @(posedge clk) begin
    if (reset) begin
      trig_s1 <= 1'b0;
      trig_s2 <= 1'b0;
      dly_s1  <= 1'b0;
      dly_s2  <= 1'b0;
    end else begin
      trig_s1 <= mon.trigger;
      trig_s2 <= trig_s1;
      dly_s1  <= mon.delay_in;
      dly_s2  <= dly_s1;
    end
  end

  assign trig_rise = trig_s1 & ~trig_s2;
  assign trig_fall = ~trig_s1 & trig_s2;
  assign dly_rise  = dly_s1 & ~dly_s2;
  assign dly_fall  = ~dly_s1 & dly_s2;
  assign trig_hit  = sel_q ? trig_fall : trig_rise;
  assign dly_hit   = dly_rise | dly_fall;
  // The closing edge is the opposite polarity of the one that opened the pulse.
  assign close_hit = pol_q ? dly_fall : dly_rise;
  // Counter holds elapsed-minus-one, so the cycle right after an edge already counts as 1.
  assign elapsed   = cnt_q + CNT_W'(1);

  // State register plus measurement datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      sel_q   <= 1'b0;
      cnt_q   <= '0;
      lead_q  <= '0;
      width_q <= '0;
      pol_q   <= 1'b0;
      tmo_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      lead_q  <= lead_d;
      width_q <= width_d;
      pol_q   <= pol_d;
      tmo_q   <= tmo_d;
      busy_q  <= (state_d == S_ARMED) || (state_d == S_LEAD) || (state_d == S_WIDTH);
      valid_q <= (state_d == S_DONE);
    end
  end

  // Next-state and next-result logic for the measurement sequence.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    lead_d  = lead_q;
    width_d = width_q;
    pol_d   = pol_q;
    tmo_d   = tmo_q;
    case (state_q)
      S_IDLE: begin
        if (mon.arm) begin
          sel_d   = mon.trig_edge_sel;
          cnt_d   = '0;
          lead_d  = '0;
          width_d = '0;
          pol_d   = 1'b0;
          tmo_d   = 1'b0;
          state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        if (trig_hit) begin
          cnt_d = '0;
          if (dly_hit) begin
            lead_d  = '0;
            pol_d   = dly_s1;
            state_d = S_WIDTH;
          end else begin
            state_d = S_LEAD;
          end
        end
      end
      S_LEAD: begin
        if (dly_hit) begin
          lead_d  = elapsed;
          pol_d   = dly_s1;
          cnt_d   = '0;
          state_d = S_WIDTH;
        end else if (elapsed == TIMEOUT) begin
          lead_d  = TIMEOUT;
          tmo_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = elapsed;
        end
      end
      S_WIDTH: begin
        if (close_hit) begin
          width_d = elapsed;
          state_d = S_DONE;
        end else if (elapsed == TIMEOUT) begin
          width_d = TIMEOUT;
          tmo_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = elapsed;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign mon.busy       = busy_q;
  assign mon.meas_valid = valid_q;
  assign mon.lead_cnt   = lead_q;
  assign mon.width_cnt  = width_q;
  assign mon.edge_pol   = pol_q;
  assign mon.timeout    = tmo_q;

endmodule
